// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state, grant and bus-width definitions for wb_arbiter_2m
package wb_arb_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - counts unanswered strobe cycles and flags a hung slave
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic stb,
  input  logic resp,
  output logic timeout
);

  logic [7:0] cnt;

  // Fire in the cycle the count has already reached its limit and the slave still has not answered
  assign timeout = active && stb && !resp && (cnt == 8'(TIMEOUT_CYC - 1));

  // Advance on every unanswered strobe cycle; any response, idle strobe, abort or leaving BUSY restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active || !stb || resp || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone classic arbiter; optional watchdog via WB_ARB_TIMEOUT_EN
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_rty_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_rty_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_rty_i,
  output logic [1:0]          gnt_o
);

  arb_state_t          state, state_n;
  logic [1:0]          gnt, gnt_n;
  logic                last_gnt, last_gnt_n;
  logic                own1;
  logic                own_cyc, own_stb, own_we;
  logic [WB_ADR_W-1:0] own_adr;
  logic [WB_DAT_W-1:0] own_dat;
  logic                busy, owned, timeout;
  logic                ack, err, rty;

  assign own1    = gnt[1];
  assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own1 ? m1_stb_i : m0_stb_i;
  assign own_we  = own1 ? m1_we_i  : m0_we_i;
  assign own_adr = own1 ? m1_adr_i : m0_adr_i;
  assign own_dat = own1 ? m1_dat_i : m0_dat_i;
  assign busy    = (state == BUSY);
  assign owned   = (gnt != GNT_NONE);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .active (busy),
    .stb    (s_stb_o),
    .resp   (s_ack_i | s_err_i | s_rty_i),
    .timeout(timeout)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
`endif

  // Slave side mirrors the owner only in BUSY, so IDLE and ABORT present a quiet bus
  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = busy & own_stb;
  assign s_we_o  = busy & own_we;
  assign s_adr_o = busy ? own_adr : '0;
  assign s_dat_o = busy ? own_dat : '0;

  // A watchdog abort replaces whatever the slave says with a single error
  assign ack = busy & ~timeout & s_ack_i;
  assign err = busy & (timeout | s_err_i);
  assign rty = busy & ~timeout & s_rty_i;

  assign m0_ack_o = ack & ~own1;
  assign m0_err_o = err & ~own1;
  assign m0_rty_o = rty & ~own1;
  assign m1_ack_o = ack & own1;
  assign m1_err_o = err & own1;
  assign m1_rty_o = rty & own1;
  assign m0_dat_o = owned ? s_dat_i : '0;
  assign m1_dat_o = owned ? s_dat_i : '0;
  assign gnt_o    = gnt;

  // Next-state: round-robin pick in IDLE, hold the owner until its cyc drops
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    last_gnt_n = last_gnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_n = BUSY;
          gnt_n   = last_gnt ? GNT_M0 : GNT_M1;
        end else if (m0_cyc_i) begin
          state_n = BUSY;
          gnt_n   = GNT_M0;
        end else if (m1_cyc_i) begin
          state_n = BUSY;
          gnt_n   = GNT_M1;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_n    = IDLE;
          gnt_n      = GNT_NONE;
          last_gnt_n = own1;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_n = ABORT;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!own_cyc) begin
          state_n    = IDLE;
          gnt_n      = GNT_NONE;
          last_gnt_n = own1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        gnt_n   = GNT_NONE;
      end
    endcase
  end

  // State, owner and round-robin history registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      gnt      <= GNT_NONE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last_gnt <= last_gnt_n;
    end
  end

endmodule
